mem_bist: RTL and testbench

Built-in self-test initiator for the single-port valid/ready memory block. It drives the memory's request side (valid, wr_rd, addr, wdata), consumes its response side (ready, rdata) and runs a full write-then-read-compare sweep over every address. It reports pass/fail, the mismatch count and the first failing address. It sits between the memory and a test controller or CPU status register.

---
 rtl/mem_bist.sv | 239 +++++++++++++++++++++++
 tb/tb_mem_bist.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_bist.sv
`default_nettype none
// -----------------------------------------------------------------------------
// mem_bist : write-then-read-compare BIST initiator for a valid/ready memory.
//            Define MEM_BIST_INV_EN to append an inverted-data write/read sweep.
// Rev 1.0
// -----------------------------------------------------------------------------
module mem_bist #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  start,
    input  logic [WIDTH-1:0]      seed,
    output logic                  valid,
    output logic                  wr_rd,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [WIDTH-1:0]      wdata,
    input  logic [WIDTH-1:0]      rdata,
    input  logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout_err,
    output logic [ADDR_WIDTH+1:0] err_count,
    output logic [ADDR_WIDTH-1:0] first_fail_addr
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [3:0] c_idle    = 4'd0;
    localparam logic [3:0] c_wr_req  = 4'd1;
    localparam logic [3:0] c_wr_wait = 4'd2;
    localparam logic [3:0] c_rd_req  = 4'd3;
    localparam logic [3:0] c_rd_wait = 4'd4;
    localparam logic [3:0] c_done    = 4'd5;
`ifdef MEM_BIST_INV_EN
    localparam logic [3:0] c_iwr_req  = 4'd6;
    localparam logic [3:0] c_iwr_wait = 4'd7;
    localparam logic [3:0] c_ird_req  = 4'd8;
    localparam logic [3:0] c_ird_wait = 4'd9;
`endif

    localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [CNT_W-1:0]      c_tmo_max   = CNT_W'(TIMEOUT - 1);

    logic [3:0]            r_state;
    logic [3:0]            w_state_nxt;
    logic [WIDTH-1:0]      r_seed;
    logic [CNT_W-1:0]      r_tmo_cnt;

    logic                  w_accept;
    logic                  w_last;
    logic                  w_tmo;
    logic                  w_wait;
    logic                  w_rd_wait;
    logic                  w_cmp_inv;
    logic                  w_mismatch;

    logic                  w_valid_nxt;
    logic                  w_wr_rd_nxt;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic [WIDTH-1:0]      w_wdata_nxt;
    logic                  w_busy_nxt;
    logic                  w_done_nxt;
    logic                  w_pass_nxt;
    logic                  w_tmo_err_nxt;
    logic [ADDR_WIDTH+1:0] w_err_nxt;
    logic [ADDR_WIDTH-1:0] w_first_nxt;
    logic [WIDTH-1:0]      w_seed_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;

    function automatic logic [WIDTH-1:0] pattern(input logic [WIDTH-1:0]      base,
                                                 input logic [ADDR_WIDTH-1:0] a,
                                                 input logic                  inv);
        logic [WIDTH-1:0] sum;
        sum = base + WIDTH'(a);
        return inv ? ~sum : sum;
    endfunction

    assign w_accept = ((r_state == c_idle) || (r_state == c_done)) && start;
    assign w_last   = (addr == c_last_addr);
    assign w_tmo    = (r_tmo_cnt == c_tmo_max);

`ifdef MEM_BIST_INV_EN
    assign w_wait    = (r_state == c_wr_wait) || (r_state == c_rd_wait) ||
                       (r_state == c_iwr_wait) || (r_state == c_ird_wait);
    assign w_rd_wait = (r_state == c_rd_wait) || (r_state == c_ird_wait);
    assign w_cmp_inv = (r_state == c_ird_wait);
`else
    assign w_wait    = (r_state == c_wr_wait) || (r_state == c_rd_wait);
    assign w_rd_wait = (r_state == c_rd_wait);
    assign w_cmp_inv = 1'b0;
`endif

    assign w_mismatch = (rdata != pattern(r_seed, addr, w_cmp_inv));

    // State register
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle, c_done: begin
                if (start) w_state_nxt = c_wr_req;
            end
            c_wr_req: w_state_nxt = c_wr_wait;
            c_wr_wait: begin
                if (ready)      w_state_nxt = w_last ? c_rd_req : c_wr_req;
                else if (w_tmo) w_state_nxt = c_done;
            end
            c_rd_req: w_state_nxt = c_rd_wait;
            c_rd_wait: begin
`ifdef MEM_BIST_INV_EN
                if (ready)      w_state_nxt = w_last ? c_iwr_req : c_rd_req;
`else
                if (ready)      w_state_nxt = w_last ? c_done : c_rd_req;
`endif
                else if (w_tmo) w_state_nxt = c_done;
            end
`ifdef MEM_BIST_INV_EN
            c_iwr_req: w_state_nxt = c_iwr_wait;
            c_iwr_wait: begin
                if (ready)      w_state_nxt = w_last ? c_ird_req : c_iwr_req;
                else if (w_tmo) w_state_nxt = c_done;
            end
            c_ird_req: w_state_nxt = c_ird_wait;
            c_ird_wait: begin
                if (ready)      w_state_nxt = w_last ? c_done : c_ird_req;
                else if (w_tmo) w_state_nxt = c_done;
            end
`endif
            default: w_state_nxt = c_idle;
        endcase
    end

    // Output logic: next values for the registered outputs, keyed on the next state
    always_comb begin
        w_valid_nxt   = 1'b0;
        w_wr_rd_nxt   = wr_rd;
        w_addr_nxt    = addr;
        w_wdata_nxt   = wdata;
        w_err_nxt     = err_count;
        w_first_nxt   = first_fail_addr;
        w_tmo_err_nxt = timeout_err;
        w_seed_nxt    = r_seed;
        w_cnt_nxt     = '0;

        if (w_accept) begin
            w_seed_nxt    = seed;
            w_addr_nxt    = '0;
            w_err_nxt     = '0;
            w_first_nxt   = '0;
            w_tmo_err_nxt = 1'b0;
        end

        if (w_wait) begin
            if (ready) begin
                w_addr_nxt = w_last ? '0 : addr + ADDR_WIDTH'(1);
                if (w_rd_wait && w_mismatch) begin
                    if (err_count != '1) w_err_nxt = err_count + (ADDR_WIDTH+2)'(1);
                    if (err_count == '0) w_first_nxt = addr;
                end
            end else begin
                w_cnt_nxt = r_tmo_cnt + CNT_W'(1);
                if (w_tmo) w_tmo_err_nxt = 1'b1;
            end
        end

        case (w_state_nxt)
            c_wr_req: begin
                w_valid_nxt = 1'b1;
                w_wr_rd_nxt = 1'b1;
                w_wdata_nxt = pattern(w_seed_nxt, w_addr_nxt, 1'b0);
            end
            c_rd_req: begin
                w_valid_nxt = 1'b1;
                w_wr_rd_nxt = 1'b0;
            end
`ifdef MEM_BIST_INV_EN
            c_iwr_req: begin
                w_valid_nxt = 1'b1;
                w_wr_rd_nxt = 1'b1;
                w_wdata_nxt = pattern(w_seed_nxt, w_addr_nxt, 1'b1);
            end
            c_ird_req: begin
                w_valid_nxt = 1'b1;
                w_wr_rd_nxt = 1'b0;
            end
`endif
            default: ;
        endcase

        w_busy_nxt = (w_state_nxt != c_idle) && (w_state_nxt != c_done);
        w_done_nxt = (w_state_nxt == c_done);
        w_pass_nxt = w_done_nxt && (w_err_nxt == '0) && !w_tmo_err_nxt;
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_seed          <= '0;
            r_tmo_cnt       <= '0;
            valid           <= 1'b0;
            wr_rd           <= 1'b0;
            addr            <= '0;
            wdata           <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            timeout_err     <= 1'b0;
            err_count       <= '0;
            first_fail_addr <= '0;
        end else begin
            r_seed          <= w_seed_nxt;
            r_tmo_cnt       <= w_cnt_nxt;
            valid           <= w_valid_nxt;
            wr_rd           <= w_wr_rd_nxt;
            addr            <= w_addr_nxt;
            wdata           <= w_wdata_nxt;
            busy            <= w_busy_nxt;
            done            <= w_done_nxt;
            pass            <= w_pass_nxt;
            timeout_err     <= w_tmo_err_nxt;
            err_count       <= w_err_nxt;
            first_fail_addr <= w_first_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_bist.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_mem_bist : table-driven bench for mem_bist with a one-cycle-latency memory.
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_mem_bist;

`ifdef MEM_BIST_INV_EN
    localparam int c_sweeps = 2;
`else
    localparam int c_sweeps = 1;
`endif

    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic        start = 1'b0;
    logic [15:0] seed = '0;
    logic        valid;
    logic        wr_rd;
    logic [3:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata = '0;
    logic        ready = 1'b0;
    logic        busy;
    logic        done;
    logic        pass;
    logic        timeout_err;
    logic [5:0]  err_count;
    logic [3:0]  first_fail_addr;

    logic [15:0] mem [16];
    logic [15:0] corrupt_mask = '0;
    logic        ready_en = 1'b1;

    int n_cmp = 0;
    int n_err = 0;
    int n_valid;
    logic [15:0] w1_data;
    logic [15:0] w15_data;

    mem_bist #(.WIDTH(16), .DEPTH(16), .TIMEOUT(64)) dut (
        .clk(clk), .res(res), .start(start), .seed(seed),
        .valid(valid), .wr_rd(wr_rd), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready),
        .busy(busy), .done(done), .pass(pass), .timeout_err(timeout_err),
        .err_count(err_count), .first_fail_addr(first_fail_addr)
    );

    always #5 clk = ~clk;

    // Memory: responds one cycle after sampling valid; reads flip bit 0 where masked
    always @(posedge clk) begin
        ready <= valid && ready_en;
        if (valid && wr_rd) mem[addr] <= wdata;
        if (valid && !wr_rd) rdata <= mem[addr] ^ {15'b0, corrupt_mask[addr]};
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_test(input string tag, input logic [15:0] s, input bit keep_start,
                            input int bound, output int cyc);
        bit seen1;
        bit seen15;
        seen1 = 0;
        seen15 = 0;
        n_valid = 0;
        w1_data = '0;
        w15_data = '0;
        @(negedge clk);
        seed = s;
        start = 1'b1;
        @(posedge clk); #1;
        if (!keep_start) start = 1'b0;
        check({tag, " E0 valid"}, {63'b0, valid}, 64'd1);
        check({tag, " E0 busy"}, {63'b0, busy}, 64'd1);
        cyc = 0;
        while (!done && cyc < bound) begin
            if (valid) begin
                n_valid++;
                if (wr_rd && addr == 4'd1 && !seen1) begin w1_data = wdata; seen1 = 1; end
                if (wr_rd && addr == 4'd15 && !seen15) begin w15_data = wdata; seen15 = 1; end
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s done wait: no done after %0d cycles", tag, bound);
        end
    endtask

    typedef struct {
        logic [15:0] seed;
        logic [15:0] mask;
        logic        exp_pass;
        int          exp_err;
        logic [3:0]  exp_first;
        logic [15:0] exp_w1;
        logic [15:0] exp_w15;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int cyc;
        string t;

        vecs[0] = '{16'h1000, 16'h0000, 1'b1, 0,  4'd0,  16'h1001, 16'h100F};
        vecs[1] = '{16'h1000, 16'h0208, 1'b0, 2,  4'd3,  16'h1001, 16'h100F};
        vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 0,  4'd0,  16'h0000, 16'h000E};
        vecs[3] = '{16'h0000, 16'h8001, 1'b0, 2,  4'd0,  16'h0001, 16'h000F};
        vecs[4] = '{16'h1234, 16'hFFFF, 1'b0, 16, 4'd0,  16'h1235, 16'h1243};
        vecs[5] = '{16'h8000, 16'h4000, 1'b0, 1,  4'd14, 16'h8001, 16'h800F};

        // Asynchronous reset with no clock edge involved
        #2 res = 1'b0;
        #1;
        check("reset outputs", {28'b0, valid, wr_rd, addr, wdata, busy, done, pass,
                                timeout_err, err_count, first_fail_addr}, 64'd0);
        @(negedge clk);
        res = 1'b1;

        for (int i = 0; i < 6; i++) begin
            corrupt_mask = vecs[i].mask;
            t = $sformatf("vec%0d", i);
            run_test(t, vecs[i].seed, 1'b0, 200 * c_sweeps, cyc);
            check({t, " done cycle"}, 64'(cyc), 64'(64 * c_sweeps));
            check({t, " pass"}, {63'b0, pass}, {63'b0, vecs[i].exp_pass});
            check({t, " err_count"}, {58'b0, err_count}, 64'(vecs[i].exp_err * c_sweeps));
            check({t, " first_fail"}, {60'b0, first_fail_addr}, {60'b0, vecs[i].exp_first});
            check({t, " timeout_err"}, {63'b0, timeout_err}, 64'd0);
            check({t, " busy"}, {63'b0, busy}, 64'd0);
            check({t, " wdata a1"}, {48'b0, w1_data}, {48'b0, vecs[i].exp_w1});
            check({t, " wdata a15"}, {48'b0, w15_data}, {48'b0, vecs[i].exp_w15});
            check({t, " valid pulses"}, 64'(n_valid), 64'(32 * c_sweeps));
        end

        // ready never arrives: timeout 64 cycles after WR_WAIT entry (E0+1)
        corrupt_mask = '0;
        ready_en = 1'b0;
        run_test("tmo", 16'h00AA, 1'b0, 200, cyc);
        check("tmo done cycle", 64'(cyc), 64'd65);
        check("tmo timeout_err", {63'b0, timeout_err}, 64'd1);
        check("tmo pass", {63'b0, pass}, 64'd0);
        check("tmo valid pulses", 64'(n_valid), 64'd1);
        check("tmo err_count", {58'b0, err_count}, 64'd0);
        ready_en = 1'b1;

        // start held high: one sweep, restart on the edge after done, status cleared
        corrupt_mask = 16'h0208;
        run_test("hold", 16'h1000, 1'b1, 200 * c_sweeps, cyc);
        check("hold done cycle", 64'(cyc), 64'(64 * c_sweeps));
        check("hold valid pulses", 64'(n_valid), 64'(32 * c_sweeps));
        check("hold err_count", {58'b0, err_count}, 64'(2 * c_sweeps));
        @(posedge clk); #1;
        check("hold restart status", {59'b0, done, pass, timeout_err, busy, valid}, 64'h3);
        check("hold restart err", {54'b0, err_count, first_fail_addr}, 64'd0);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 200 * c_sweeps) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("hold second done", {63'b0, done}, 64'd1);
        check("hold second err", {58'b0, err_count}, 64'(2 * c_sweeps));

        // reset mid-way through the read sweep
        corrupt_mask = '0;
        @(negedge clk);
        seed = 16'h2222;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (40) @(posedge clk);
        #3 res = 1'b0;
        #1;
        check("midreset outputs", {28'b0, valid, wr_rd, addr, wdata, busy, done, pass,
                                   timeout_err, err_count, first_fail_addr}, 64'd0);
        @(negedge clk);
        res = 1'b1;
        @(posedge clk); #1;
        check("midreset idle", {62'b0, busy, done}, 64'd0);
        run_test("after_reset", 16'h5555, 1'b0, 200 * c_sweeps, cyc);
        check("after_reset done cycle", 64'(cyc), 64'(64 * c_sweeps));
        check("after_reset pass", {63'b0, pass}, 64'd1);
        check("after_reset err", {58'b0, err_count}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
